regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Writeback sequencer that drives the 64-bit register file write port (`regWrite`/`wr`/`wdata`) from two producers: single-cycle ALU results and multi-cycle load results. ALU results take priority. Load results are sign/zero-extended and buffered in a small in-order queue, then drained into the register file in idle ALU slots. The block also reports per-register pending status to decode for hazard stalls and squashes stale queued loads overwritten by younger ALU writes.

## Interface
- `DEPTH`, 4: load queue entries (power of two, ≥2)
- `XLEN`, 64: data width

- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `alu_valid`  in  1  ALU result present this cycle
- `alu_rd`  in  5  ALU destination register
- `alu_data`  in  XLEN  ALU result
- `ld_valid`  in  1  load result offered
- `ld_ready`  out  1  queue can accept (`count < DEPTH`)
- `ld_rd`  in  5  load destination register
- `ld_data`  in  XLEN  raw memory data, right-aligned
- `ld_size`  in  2  00 byte, 01 half, 10 word, 11 double
- `ld_unsigned`  in  1  1 = zero-extend, 0 = sign-extend
- `chk_rs1`, `chk_rs2`  in  5  registers queried by decode
- `busy1`, `busy2`  out  1  write to `chk_rs1`/`chk_rs2` still pending
- `regWrite`  out  1  register file write enable (registered)
- `wr`  out  5  register file write address (registered)
- `wdata`  out  XLEN  register file write data (registered)
- `count`  out  clog2(DEPTH+1)  occupied queue entries

## Operation
- Load accept: handshake on `ld_valid && ld_ready` at a rising edge.
  - Extension happens at enqueue. Source bits: 7, 15, 31 or 63. Sign-extend unless `ld_unsigned`; `ld_unsigned` is ignored for size 11.
  - Accepted load with `ld_rd == 0` is consumed and not enqueued.
- Queue entry fields: rd, data, live bit. Circular FIFO with wrapping read/write pointers.
- Per-cycle selection, evaluated before the edge:
  1. `alu_valid && alu_rd != 0`: output stage loads `{1, alu_rd, alu_data}`. Queue does not pop.
  2. Otherwise, if the queue is non-empty: pop the head. Output stage loads `{head.live, head.rd, head.data}`. A dead entry consumes the slot with `regWrite=0`.
  3. Otherwise: `regWrite=0`. `wr` and `wdata` hold their previous values.
- `alu_valid` with `alu_rd == 0` counts as no ALU request, so the queue may drain that cycle.
- Squash: an ALU write selected to rd X clears the live bit of every entry already in the queue with rd X.
  - A load accepted in the same cycle with rd X is younger than that ALU write. It enqueues live.
- Push and pop may occur in the same cycle.
  - `ld_ready` depends only on `count`. When full, it stays 0 even if a pop occurs that cycle.
  - `count` is unchanged on simultaneous push and pop.
- Busy (combinational), for query register r ≠ 0, asserted when either holds:
  - a live queue entry has rd r; or
  - `regWrite && wr == r` (write not yet committed to the register file).
- Busy is always 0 for r = 0.
- Reset values:
  - `regWrite=0`, `wr=0`, `wdata=0`
  - queue empty, pointers 0, `count=0`
  - hence `ld_ready=1`, `busy1=busy2=0`
- Reset in the middle of operation discards all queued loads, including live ones. No write is issued for them.

## Timing
- ALU result presented in cycle N → `regWrite=1` during cycle N+1 → register file written at the end of N+1.
- Load accepted at edge N: earliest pop is in cycle N+1 (edge N+1), so `regWrite=1` during cycle N+2.
  - Each consecutive cycle with a valid ALU request adds one cycle of delay.
- Queue drains in order at one entry per ALU-idle cycle. No bypass of the queue.
- Continuous ALU traffic can stall the queue indefinitely. Backpressure to the load source is via `ld_ready` only.
- `busy*` reflects state after the most recent edge. It is valid combinationally in the same cycle for decode.

## Test plan
- Reset, then ALU `rd=5`, data `0x1234` in cycle 1 → `regWrite=1`, `wr=5`, `wdata=0x1234` during cycle 2. `busy` for 5 is 1 during cycle 2, 0 in cycle 3.
- Load extension, with ALU idle:
  - byte `0x80`, signed → `0xFFFF_FFFF_FFFF_FF80`
  - half `0x8000`, unsigned → `0x0000_0000_0000_8000`
  - word `0x7FFF_FFFF`, signed → `0x0000_0000_7FFF_FFFF`
  - each written 2 cycles after accept.
- Fill the queue with 4 loads while the ALU is busy every cycle:
  - `ld_ready=0`, `count=4`; a 5th `ld_valid` is not accepted.
  - Release the ALU → 4 writes on 4 consecutive cycles in order, then `ld_ready=1`.
- Squash, in order:
  - queue a load to `rd=7` with data `0xAA` while the ALU is busy;
  - ALU write to `rd=7` with data `0xBB` → written, `busy` for 7 is 0 after the output stage clears;
  - the load pops later with `regWrite=0`; x7 ends as `0xBB`.
- Same cycle: ALU `rd=9` and accepted load `rd=9` → ALU write first, then the load writes `rd=9` (live).
- Load and ALU writes to `rd=0` → never `regWrite=1`, `busy` for 0 always 0.
- Assert `reset` with 3 live entries → next cycle `count=0`, `regWrite=0`, and no queued write ever appears.

Source files
------------

// File: rtl/regfile_writeback.sv
// Writeback sequencer for the register file write port.
// ALU results win the port; load results are extended on entry to a small
// in-order queue and drained into ALU-idle slots. Younger ALU writes squash
// older queued loads to the same register, and per-register pending status
// is reported to decode.
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [4:0]                 ld_rd,
    input  logic [XLEN-1:0]            ld_data,
    input  logic [1:0]                 ld_size,
    input  logic                       ld_unsigned,
    input  logic [4:0]                 chk_rs1,
    input  logic [4:0]                 chk_rs2,
    output logic                       busy1,
    output logic                       busy2,
    output logic                       regWrite,
    output logic [4:0]                 wr,
    output logic [XLEN-1:0]            wdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [4:0]      q_rd_q   [DEPTH];
    logic [4:0]      q_rd_d   [DEPTH];
    logic [XLEN-1:0] q_data_q [DEPTH];
    logic [XLEN-1:0] q_data_d [DEPTH];
    logic            q_live_q [DEPTH];
    logic            q_live_d [DEPTH];

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    logic            regwrite_q, regwrite_d;
    logic [4:0]      wr_q,       wr_d;
    logic [XLEN-1:0] wdata_q,    wdata_d;

    logic            alu_sel;
    logic            push;
    logic            enq;
    logic            pop;
    logic [XLEN-1:0] ld_ext;
    logic            hit1;
    logic            hit2;

    assign ld_ready = (count_q < CW'(DEPTH));
    assign regWrite = regwrite_q;
    assign wr       = wr_q;
    assign wdata    = wdata_q;
    assign count    = count_q;

    // Sign/zero-extend the raw load data according to its access size
    always_comb begin
        ld_ext = ld_data;
        unique case (ld_size)
            2'b00:   ld_ext = {{(XLEN-8){~ld_unsigned & ld_data[7]}},   ld_data[7:0]};
            2'b01:   ld_ext = {{(XLEN-16){~ld_unsigned & ld_data[15]}}, ld_data[15:0]};
            2'b10:   ld_ext = {{(XLEN-32){~ld_unsigned & ld_data[31]}}, ld_data[31:0]};
            default: ld_ext = ld_data;
        endcase
    end

    // Write-port arbitration, squash, queue push/pop and next output stage.
    // A popped slot has its live bit cleared so that only occupied live
    // entries can ever report busy.
    always_comb begin
        alu_sel = alu_valid && (alu_rd != 5'd0);
        push    = ld_valid && ld_ready;
        enq     = push && (ld_rd != 5'd0);
        pop     = !alu_sel && (count_q != '0);

        q_rd_d     = q_rd_q;
        q_data_d   = q_data_q;
        q_live_d   = q_live_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        regwrite_d = 1'b0;
        wr_d       = wr_q;
        wdata_d    = wdata_q;

        if (alu_sel) begin
            regwrite_d = 1'b1;
            wr_d       = alu_rd;
            wdata_d    = alu_data;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (q_rd_q[i] == alu_rd) begin
                    q_live_d[i] = 1'b0;
                end
            end
        end else if (pop) begin
            regwrite_d         = q_live_q[rd_ptr_q];
            wr_d               = q_rd_q[rd_ptr_q];
            wdata_d            = q_data_q[rd_ptr_q];
            q_live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d           = rd_ptr_q + PW'(1);
        end

        // Enqueue after the squash so a same-cycle load stays live
        if (enq) begin
            q_rd_d[wr_ptr_q]   = ld_rd;
            q_data_d[wr_ptr_q] = ld_ext;
            q_live_d[wr_ptr_q] = 1'b1;
            wr_ptr_d           = wr_ptr_q + PW'(1);
        end

        count_d = count_q + CW'(enq) - CW'(pop);
    end

    // Pending-write lookup for the two decode query ports
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (q_live_q[i] && (q_rd_q[i] == chk_rs1)) hit1 = 1'b1;
            if (q_live_q[i] && (q_rd_q[i] == chk_rs2)) hit2 = 1'b1;
        end
        busy1 = (chk_rs1 != 5'd0) && (hit1 || (regwrite_q && (wr_q == chk_rs1)));
        busy2 = (chk_rs2 != 5'd0) && (hit2 || (regwrite_q && (wr_q == chk_rs2)));
    end

    // State registers; reset discards every queued load
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_rd_q[i]   <= '0;
                q_data_q[i] <= '0;
                q_live_q[i] <= 1'b0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            regwrite_q <= 1'b0;
            wr_q       <= '0;
            wdata_q    <= '0;
        end else begin
            q_rd_q     <= q_rd_d;
            q_data_q   <= q_data_d;
            q_live_q   <= q_live_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            regwrite_q <= regwrite_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: a queue-based reference model
// predicts every register-file write (with its cycle), and a monitor
// compares them as the DUT presents regWrite.
module tb_regfile_writeback;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        bit          live;
    } ent_t;

    typedef struct {
        int          cyc;
        logic [4:0]  wr;
        logic [63:0] data;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [63:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_rd = '0;
    logic [63:0] ld_data = '0;
    logic [1:0]  ld_size = '0;
    logic        ld_unsigned = 1'b0;
    logic [4:0]  chk_rs1 = '0;
    logic [4:0]  chk_rs2 = '0;
    logic        busy1, busy2;
    logic        regWrite;
    logic [4:0]  wr;
    logic [63:0] wdata;
    logic [2:0]  count;

    regfile_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd),
        .ld_data(ld_data), .ld_size(ld_size), .ld_unsigned(ld_unsigned),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .busy1(busy1), .busy2(busy2),
        .regWrite(regWrite), .wr(wr), .wdata(wdata), .count(count)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    ent_t        mq[$];
    wr_t         exp_q[$];
    bit          m_init = 0;
    bit          m_rw = 0;
    logic [4:0]  m_wr = '0;
    logic [63:0] m_wd = '0;
    logic [63:0] rf [32];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_ext(logic [63:0] raw, logic [1:0] size, bit uns);
        int          bits;
        logic [63:0] mask;
        logic [63:0] v;
        bits = 8 << size;
        if (bits == 64) return raw;
        mask = (64'd1 << bits) - 64'd1;
        v = raw & mask;
        if (!uns && raw[bits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit mbusy(logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (m_rw && m_wr == r) return 1'b1;
        foreach (mq[i]) if (mq[i].live && mq[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: every DUT write must match the oldest predicted write
    initial begin
        wr_t e;
        foreach (rf[i]) rf[i] = '0;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            if (regWrite === 1'b1) begin
                rf[wr] = wdata;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got wr=%0d data=%h expected none (cycle %0d)", wr, wdata, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_cycle", 64'(cyc), 64'(e.cyc));
                    chk("write_rd", 64'(wr), 64'(e.wr));
                    chk("write_data", wdata, e.data);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_write: got none expected wr=%0d data=%h (cycle %0d)", e.wr, e.data, cyc);
            end
        end
    end

    // One cycle: check state outputs against the model, drive inputs, advance model
    task automatic step(bit rst, bit av, logic [4:0] ar, logic [63:0] ad,
                        bit lv, logic [4:0] lr, logic [63:0] ldat, logic [1:0] ls,
                        bit lu, logic [4:0] c1, logic [4:0] c2);
        bit   alu_sel;
        bit   accept;
        ent_t e;
        @(negedge clock);
        if (m_init) begin
            chk("count", 64'(count), 64'(mq.size()));
            chk("ld_ready", 64'(ld_ready), 64'(mq.size() < DEPTH));
            chk("busy1", 64'(busy1), 64'(mbusy(chk_rs1)));
            chk("busy2", 64'(busy2), 64'(mbusy(chk_rs2)));
            chk("regWrite", 64'(regWrite), 64'(m_rw));
            chk("wr", 64'(wr), 64'(m_wr));
            chk("wdata", wdata, m_wd);
        end
        reset = rst; alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_valid = lv; ld_rd = lr; ld_data = ldat; ld_size = ls; ld_unsigned = lu;
        chk_rs1 = c1; chk_rs2 = c2;
        if (rst) begin
            mq.delete();
            m_rw = 0; m_wr = '0; m_wd = '0; m_init = 1;
        end else begin
            alu_sel = av && (ar != 5'd0);
            accept  = lv && (mq.size() < DEPTH);
            if (alu_sel) begin
                foreach (mq[i]) if (mq[i].rd == ar) mq[i].live = 1'b0;
                exp_q.push_back('{cyc: cyc + 1, wr: ar, data: ad});
                m_rw = 1; m_wr = ar; m_wd = ad;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                if (e.live) exp_q.push_back('{cyc: cyc + 1, wr: e.rd, data: e.data});
                m_rw = e.live; m_wr = e.rd; m_wd = e.data;
            end else begin
                m_rw = 0;
            end
            if (accept && lr != 5'd0)
                mq.push_back('{rd: lr, data: ref_ext(ldat, ls, lu), live: 1'b1});
        end
    endtask

    task automatic idle(logic [4:0] c1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, c1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        chk("rst_regWrite", 64'(regWrite), 64'd0);
        chk("rst_wr", 64'(wr), 64'd0);
        chk("rst_wdata", wdata, 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ld_ready", 64'(ld_ready), 64'd1);

        // ALU write latency and output-stage busy
        step(0, 1, 5, 64'h1234, 0, 0, 0, 0, 0, 5, 0);
        idle(5); #1;
        chk("alu_regWrite", 64'(regWrite), 64'd1);
        chk("alu_wr", 64'(wr), 64'd5);
        chk("alu_wdata", wdata, 64'h1234);
        chk("alu_busy5", 64'(busy1), 64'd1);
        idle(5); #1;
        chk("alu_busy5_clear", 64'(busy1), 64'd0);

        // Load extension, written two cycles after accept
        step(0, 0, 0, 0, 1, 3, 64'h80, 2'b00, 0, 0, 0); idle(0); idle(0); #1;
        chk("ext_byte_signed", wdata, 64'hFFFF_FFFF_FFFF_FF80);
        chk("ext_byte_wr", 64'(wr), 64'd3);
        step(0, 0, 0, 0, 1, 4, 64'h8000, 2'b01, 1, 0, 0); idle(0); idle(0); #1;
        chk("ext_half_unsigned", wdata, 64'h0000_0000_0000_8000);
        step(0, 0, 0, 0, 1, 6, 64'h7FFF_FFFF, 2'b10, 0, 0, 0); idle(0); idle(0); #1;
        chk("ext_word_signed", wdata, 64'h0000_0000_7FFF_FFFF);

        // Fill the queue under continuous ALU traffic
        for (int i = 0; i < 4; i++)
            step(0, 1, 1, 64'(i), 1, 5'(10 + i), 64'(100 + i), 2'b11, 0, 0, 0);
        step(0, 1, 1, 64'h55, 1, 14, 64'h999, 2'b11, 0, 0, 0);
        step(0, 1, 1, 64'h56, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("full_count", 64'(count), 64'd4);
        chk("full_ld_ready", 64'(ld_ready), 64'd0);
        for (int i = 0; i < 6; i++) idle(0);
        #1;
        chk("drained_ld_ready", 64'(ld_ready), 64'd1);

        // Squash of a queued load by a younger ALU write
        step(0, 1, 1, 64'h1, 1, 7, 64'hAA, 2'b11, 0, 7, 0);
        step(0, 1, 7, 64'hBB, 0, 0, 0, 0, 0, 7, 0);
        idle(7);
        idle(7); #1;
        chk("squash_busy7", 64'(busy1), 64'd0);
        chk("squash_dead_pop", 64'(regWrite), 64'd0);
        idle(0); idle(0);
        chk("squash_x7", rf[7], 64'hBB);

        // Same-cycle ALU and load to the same register
        step(0, 1, 9, 64'h99, 1, 9, 64'h55, 2'b11, 0, 9, 0);
        idle(9); idle(9); idle(9); idle(0);
        chk("same_cycle_x9", rf[9], 64'h55);

        // Writes to x0 never reach the port
        step(0, 1, 0, 64'hDEAD, 1, 0, 64'hBEEF, 2'b11, 0, 0, 0);
        idle(0); #1;
        chk("x0_busy", 64'(busy1), 64'd0);
        idle(0); idle(0);

        // Reset discards live queued loads
        for (int i = 0; i < 3; i++)
            step(0, 1, 2, 64'(i), 1, 5'(20 + i), 64'(200 + i), 2'b11, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 20, 21);
        idle(20); #1;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_regWrite", 64'(regWrite), 64'd0);
        for (int i = 0; i < 6; i++) idle(20);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                 $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        for (int i = 0; i < 50 && (mq.size() > 0 || exp_q.size() > 0); i++) idle(0);
        idle(0); idle(0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
